// File: rtl/led_pkg.sv
// Shared state encoding and default parameters for the LED sequencer.
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } led_state_t;

  localparam int LED_NB_LEDS    = 4;
  localparam int LED_COUNT_LIM0 = 2**23;
  localparam int LED_COUNT_LIM1 = 2**24;
  localparam int LED_COUNT_LIM2 = 2**25;
  localparam int LED_COUNT_LIM3 = 2**26;

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler with switch-selected period; emits a registered one-clock tick
// each time the count reaches the selected limit.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int NB_COUNTER = 32,
  parameter int COUNT_LIM0 = LED_COUNT_LIM0,
  parameter int COUNT_LIM1 = LED_COUNT_LIM1,
  parameter int COUNT_LIM2 = LED_COUNT_LIM2,
  parameter int COUNT_LIM3 = LED_COUNT_LIM3
) (
  input  logic       clock,
  input  logic       i_reset,
  input  logic       i_clear,
  input  logic       i_run,
  input  logic [1:0] i_sel,
  output logic       o_tick
);

  logic [NB_COUNTER-1:0] presc;
  logic [NB_COUNTER-1:0] limit;
  logic                  at_limit;

  always_comb begin
    limit = NB_COUNTER'(COUNT_LIM0);
    case (i_sel)
      2'd0: limit = NB_COUNTER'(COUNT_LIM0);
      2'd1: limit = NB_COUNTER'(COUNT_LIM1);
      2'd2: limit = NB_COUNTER'(COUNT_LIM2);
      2'd3: limit = NB_COUNTER'(COUNT_LIM3);
    endcase
  end

  // >= so a speed change below the current count fires at once instead of wrapping
  assign at_limit = (presc >= (limit - NB_COUNTER'(1)));

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      presc  <= '0;
      o_tick <= 1'b0;
    end else if (i_clear) begin
      presc  <= '0;
      o_tick <= 1'b0;
    end else if (i_run) begin
      presc  <= at_limit ? '0 : presc + NB_COUNTER'(1);
      o_tick <= at_limit;
    end else begin
      o_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED shift-register sequencer: FSM, lit-position and rotation counters.
// Optional autostop (DONE state, AUTOSTOP_ROTS) is built when LED_SEQ_AUTOSTOP_EN is defined.
//
// state | meaning
// IDLE  | counters held at 0, waiting for i_enable
// RUN   | prescaler counting, strobes issued
// PAUSE | prescaler, position and rotations frozen
// DONE  | autostop reached, no strobes until i_enable drops
module led_seq_ctrl
  import led_pkg::*;
#(
  parameter int NB_LEDS    = LED_NB_LEDS,
  parameter int NB_COUNTER = 32,
  parameter int COUNT_LIM0 = LED_COUNT_LIM0,
  parameter int COUNT_LIM1 = LED_COUNT_LIM1,
  parameter int COUNT_LIM2 = LED_COUNT_LIM2,
  parameter int COUNT_LIM3 = LED_COUNT_LIM3,
  parameter int NB_ROT     = 8
`ifdef LED_SEQ_AUTOSTOP_EN
  , parameter int AUTOSTOP_ROTS = 4
`endif
) (
  input  logic                       clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_pause,
  input  logic [1:0]                 i_sel,
  output logic                       o_valid,
  output logic                       o_sr_init,
  output logic [1:0]                 o_state,
  output logic [$clog2(NB_LEDS)-1:0] o_pos,
  output logic [NB_ROT-1:0]          o_rot_cnt,
  output logic                       o_done
);

  localparam int NB_POS = $clog2(NB_LEDS);
  localparam logic [NB_POS-1:0] POS_LAST = NB_POS'(NB_LEDS - 1);

  led_state_t        state, state_nxt;
  logic              wrap;
  logic [NB_ROT-1:0] rot_next;

  led_tick_gen #(
    .NB_COUNTER (NB_COUNTER),
    .COUNT_LIM0 (COUNT_LIM0),
    .COUNT_LIM1 (COUNT_LIM1),
    .COUNT_LIM2 (COUNT_LIM2),
    .COUNT_LIM3 (COUNT_LIM3)
  ) u_tick (
    .clock   (clock),
    .i_reset (i_reset),
    .i_clear (state == ST_IDLE),
    .i_run   ((state == ST_RUN) && i_enable),
    .i_sel   (i_sel),
    .o_tick  (o_valid)
  );

  assign wrap     = o_valid && (o_pos == POS_LAST);
  assign rot_next = o_rot_cnt + NB_ROT'(wrap);

  always_comb begin
    state_nxt = state;
    if (!i_enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_nxt = ST_RUN;
        ST_RUN: begin
          if (i_pause) state_nxt = ST_PAUSE;
`ifdef LED_SEQ_AUTOSTOP_EN
          if (rot_next == NB_ROT'(AUTOSTOP_ROTS)) state_nxt = ST_DONE;
`endif
        end
        ST_PAUSE: if (!i_pause) state_nxt = ST_RUN;
        default:  state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      o_sr_init <= 1'b0;
    end else begin
      state     <= state_nxt;
      o_sr_init <= (state == ST_IDLE) && i_enable;
    end
  end

  // Position follows the issued strobe, so a strobe that lands on a pause still counts
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      o_pos     <= '0;
      o_rot_cnt <= '0;
    end else if (state == ST_IDLE) begin
      o_pos     <= '0;
      o_rot_cnt <= '0;
    end else if (o_valid) begin
      o_pos     <= wrap ? '0 : o_pos + NB_POS'(1);
      o_rot_cnt <= rot_next;
    end
  end

  assign o_state = state;

`ifdef LED_SEQ_AUTOSTOP_EN
  assign o_done = (state == ST_DONE);
`else
  assign o_done = 1'b0;
`endif

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with short prescaler limits (4/8/16/32).
module tb_led_seq_ctrl;

  logic       clock = 1'b0;
  logic       i_reset, i_enable, i_pause;
  logic [1:0] i_sel;
  logic       o_valid, o_sr_init, o_done;
  logic [1:0] o_state, o_pos;
  logic [7:0] o_rot_cnt;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  led_seq_ctrl #(
    .NB_LEDS    (4),
    .NB_COUNTER (32),
    .COUNT_LIM0 (4),
    .COUNT_LIM1 (8),
    .COUNT_LIM2 (16),
    .COUNT_LIM3 (32),
    .NB_ROT     (8)
`ifdef LED_SEQ_AUTOSTOP_EN
    , .AUTOSTOP_ROTS (2)
`endif
  ) dut (
    .clock     (clock),
    .i_reset   (i_reset),
    .i_enable  (i_enable),
    .i_pause   (i_pause),
    .i_sel     (i_sel),
    .o_valid   (o_valid),
    .o_sr_init (o_sr_init),
    .o_state   (o_state),
    .o_pos     (o_pos),
    .o_rot_cnt (o_rot_cnt),
    .o_done    (o_done)
  );

  typedef struct {
    logic       en;
    logic       pause;
    logic [1:0] sel;
    logic       v;
    logic       init;
    logic [1:0] st;
    logic [1:0] pos;
    logic [7:0] rot;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic en, input logic pa, input logic [1:0] sel, input logic v,
                     input logic init, input logic [1:0] st, input logic [1:0] pos,
                     input logic [7:0] rot);
    vec_t r;
    r.en = en; r.pause = pa; r.sel = sel; r.v = v;
    r.init = init; r.st = st; r.pos = pos; r.rot = rot;
    tbl.push_back(r);
  endtask

  task automatic do_reset();
    i_reset  = 1'b1;
    i_enable = 1'b0;
    i_pause  = 1'b0;
    i_sel    = 2'd0;
    step();
    step();
    i_reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv, ni, cyc;

    //  en pa sel  v  i  st pos rot
    add(1, 0, 0,   0, 1, 1, 0, 0);
    add(1, 0, 0,   0, 0, 1, 0, 0);
    add(1, 0, 0,   0, 0, 1, 0, 0);
    add(1, 0, 0,   0, 0, 1, 0, 0);
    add(1, 0, 0,   1, 0, 1, 0, 0);
    add(1, 0, 0,   0, 0, 1, 1, 0);
    add(1, 0, 0,   0, 0, 1, 1, 0);
    add(1, 0, 0,   0, 0, 1, 1, 0);
    add(1, 0, 0,   1, 0, 1, 1, 0);
    add(1, 0, 0,   0, 0, 1, 2, 0);
    add(1, 0, 0,   0, 0, 1, 2, 0);
    add(1, 0, 0,   0, 0, 1, 2, 0);
    add(1, 0, 0,   1, 0, 1, 2, 0);
    add(1, 0, 0,   0, 0, 1, 3, 0);
    add(1, 0, 0,   0, 0, 1, 3, 0);
    add(1, 0, 0,   0, 0, 1, 3, 0);
    add(1, 0, 0,   1, 0, 1, 3, 0);
    add(1, 0, 0,   0, 0, 1, 0, 1);
    add(1, 0, 0,   0, 0, 1, 0, 1);
    add(1, 0, 0,   0, 0, 1, 0, 1);
    add(1, 0, 0,   1, 0, 1, 0, 1);
    add(1, 0, 0,   0, 0, 1, 1, 1);
    add(1, 1, 0,   0, 0, 2, 1, 1);
    add(1, 1, 0,   0, 0, 2, 1, 1);
    add(1, 0, 0,   0, 0, 1, 1, 1);
    add(1, 0, 0,   0, 0, 1, 1, 1);
    add(1, 0, 0,   1, 0, 1, 1, 1);
    add(1, 0, 0,   0, 0, 1, 2, 1);
    add(1, 0, 0,   0, 0, 1, 2, 1);
    add(1, 0, 0,   0, 0, 1, 2, 1);
    add(1, 1, 0,   1, 0, 2, 2, 1);  // strobe lands on the pause cycle
    add(1, 1, 0,   0, 0, 2, 3, 1);
    add(1, 1, 0,   0, 0, 2, 3, 1);
    add(0, 1, 0,   0, 0, 0, 3, 1);
    add(0, 0, 0,   0, 0, 0, 0, 0);
    add(1, 0, 0,   0, 1, 1, 0, 0);

    do_reset();
    chk("reset state", o_state, 0);
    chk("reset valid", o_valid, 0);
    chk("reset init", o_sr_init, 0);
    chk("reset pos", o_pos, 0);
    chk("reset rot", o_rot_cnt, 0);
    chk("reset done", o_done, 0);

    foreach (tbl[i]) begin
      i_enable = tbl[i].en;
      i_pause  = tbl[i].pause;
      i_sel    = tbl[i].sel;
      step();
      chk($sformatf("vec%0d valid", i), o_valid, tbl[i].v);
      chk($sformatf("vec%0d init", i), o_sr_init, tbl[i].init);
      chk($sformatf("vec%0d state", i), o_state, tbl[i].st);
      chk($sformatf("vec%0d pos", i), o_pos, tbl[i].pos);
      chk($sformatf("vec%0d rot", i), o_rot_cnt, tbl[i].rot);
      chk($sformatf("vec%0d done", i), o_done, 0);
    end

    // Speed change with the prescaler already past the new limit
    do_reset();
    i_sel = 2'd3;
    i_enable = 1'b1;
    step();
    chk("selsw init", o_sr_init, 1);
    nv = 0;
    repeat (20) begin
      step();
      if (o_valid) nv++;
    end
    chk("selsw quiet at sel3", nv, 0);
    i_sel = 2'd1;
    step();
    chk("selsw immediate strobe", o_valid, 1);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("selsw period k%0d", k), o_valid, (k % 8 == 0) ? 1 : 0);
    end

    // Long pause mid-count
    do_reset();
    i_enable = 1'b1;
    step();
    step();
    step();
    i_pause = 1'b1;
    step();
    chk("pause state", o_state, 2);
    nv = 0;
    ni = 0;
    repeat (50) begin
      step();
      if (o_valid) nv++;
      if (o_sr_init) ni++;
    end
    chk("pause no strobe", nv, 0);
    chk("pause no init", ni, 0);
    chk("pause pos held", o_pos, 0);
    i_pause = 1'b0;
    step();
    chk("resume state", o_state, 1);
    chk("resume no init", o_sr_init, 0);
    chk("resume valid0", o_valid, 0);
    step();
    chk("resume strobe", o_valid, 1);
    step();
    chk("resume pos", o_pos, 1);

    // Three rotations, then disable and restart
    do_reset();
    i_enable = 1'b1;
    nv = 0;
    cyc = 0;
    while (nv < 12 && cyc < 200) begin
      step();
      if (o_valid) nv++;
      cyc++;
    end
    chk("rot3 strobes", nv, 12);
    step();
    chk("rot3 count", o_rot_cnt, 3);
    chk("rot3 pos", o_pos, 0);
    i_enable = 1'b0;
    step();
    chk("disable state", o_state, 0);
    step();
    chk("disable rot cleared", o_rot_cnt, 0);
    chk("disable pos cleared", o_pos, 0);
    i_enable = 1'b1;
    step();
    chk("restart init", o_sr_init, 1);
    chk("restart state", o_state, 1);

    // Async reset between edges mid-run
    repeat (9) step();
    chk("prereset pos", o_pos, 2);
    #3;
    i_reset = 1'b1;
    #1;
    chk("async state", o_state, 0);
    chk("async pos", o_pos, 0);
    chk("async rot", o_rot_cnt, 0);
    chk("async valid", o_valid, 0);
    chk("async init", o_sr_init, 0);
    i_enable = 1'b0;
    step();
    step();
    i_reset = 1'b0;
    nv = 0;
    ni = 0;
    repeat (20) begin
      step();
      if (o_valid) nv++;
      if (o_sr_init) ni++;
    end
    chk("post reset no strobe", nv, 0);
    chk("post reset no init", ni, 0);
    chk("post reset state", o_state, 0);

`ifdef LED_SEQ_AUTOSTOP_EN
    do_reset();
    i_enable = 1'b1;
    nv = 0;
    cyc = 0;
    while (nv < 8 && cyc < 200) begin
      step();
      if (o_valid) nv++;
      cyc++;
    end
    chk("auto strobes", nv, 8);
    step();
    chk("auto state done", o_state, 3);
    chk("auto done", o_done, 1);
    chk("auto pos", o_pos, 0);
    nv = 0;
    repeat (100) begin
      step();
      if (o_valid) nv++;
    end
    chk("auto no strobe", nv, 0);
    i_enable = 1'b0;
    step();
    chk("auto exit state", o_state, 0);
    chk("auto exit done", o_done, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Sequencer that drives the LED shift register's `i_valid` and `i_reset` inputs.
- Generates a one-cycle shift strobe at a switch-selectable rate and runs an IDLE/RUN/PAUSE state machine.
- Issues a one-cycle init pulse to the register on each start and counts completed full rotations.
- Sits between board switches and the shift register in the LED top level.

Parameters:
- NB_LEDS, 4, number of LED positions in the rotation (one rotation = NB_LEDS strobes).
- NB_COUNTER, 32, prescaler counter width.
- COUNT_LIM0, 2**23, prescaler period in clocks for i_sel=0.
- COUNT_LIM1, 2**24, period for i_sel=1.
- COUNT_LIM2, 2**25, period for i_sel=2.
- COUNT_LIM3, 2**26, period for i_sel=3.
- NB_ROT, 8, width of the rotation counter.

Ports:
- clock  input  1  system clock, all logic rising-edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_enable  input  1  level; 1 = run the sequence, 0 = return to IDLE.
- i_pause  input  1  level; 1 = freeze the sequence while enabled.
- i_sel  input  2  speed select, chooses COUNT_LIMn.
- o_valid  output  1  shift strobe to the register, one clock wide.
- o_sr_init  output  1  init pulse to the register's reset, one clock wide.
- o_state  output  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE.
- o_pos  output  $clog2(NB_LEDS)  index of the currently lit LED.
- o_rot_cnt  output  NB_ROT  completed full rotations, wraps modulo 2**NB_ROT.
- o_done  output  1  autostop reached (see Optional Feature).

Behaviour:
- Reset (async assert, clocked deassert): state=IDLE; prescaler=0; o_valid=0; o_sr_init=0; o_pos=0; o_rot_cnt=0; o_done=0.
- All outputs are registered; no combinational path from input to output.
- IDLE:
  - prescaler, o_pos and o_rot_cnt are held at 0.
  - i_enable=1 → RUN; o_sr_init=1 on the first RUN cycle only.
- RUN:
  - prescaler increments each clock.
  - When prescaler >= limit(i_sel)-1: prescaler←0 and o_valid=1 on the next cycle.
  - On each strobe, o_pos←(o_pos==NB_LEDS-1)?0:o_pos+1.
  - On the strobe that wraps o_pos to 0, o_rot_cnt increments.
- PAUSE: prescaler, o_pos and o_rot_cnt hold; o_valid=0.
- Transitions, priority in order:
  - i_enable=0 → IDLE from any state (clears the counters the next cycle).
  - Else in RUN: i_pause=1 → PAUSE.
  - Else in PAUSE: i_pause=0 → RUN, with no o_sr_init.
- Strobe and pause in the same cycle: the strobe already computed from the prior prescaler is still issued; subsequent strobes are suppressed.
- i_sel change mid-count: the comparison uses >=. If the prescaler is already past the new limit, a strobe fires the next cycle and the count restarts. No count is lost or duplicated.
- o_sr_init and o_valid are never high in the same cycle. The prescaler starts from 0 on the init cycle, so the first strobe comes limit cycles after o_sr_init.
- Reset asserted mid-RUN: all state returns to reset values immediately. No strobe or init pulse is generated until i_enable is sampled high after reset release.
- Limits are >= 2; a limit of 1 is unsupported.

Optional Feature:
- Macro: LED_SEQ_AUTOSTOP_EN.
- Defined:
  - Adds parameter AUTOSTOP_ROTS (default 4).
  - When o_rot_cnt reaches AUTOSTOP_ROTS, RUN → DONE: o_done=1, no further strobes, o_pos holds at 0.
  - DONE exits only via i_enable=0 → IDLE, which clears o_done.
- Undefined: the DONE state does not exist; o_done is tied to 0; the sequence is free-running and o_rot_cnt wraps.

Decomposition:
- Package led_pkg holds:
  - state encoding constants ST_IDLE=0, ST_RUN=1, ST_PAUSE=2, ST_DONE=3;
  - default COUNT_LIMn values;
  - NB_LEDS default.
- One sub-module, led_tick_gen: prescaler plus 4:1 limit select, producing the registered one-cycle tick. led_seq_ctrl owns the FSM, position and rotation counters.

Test Plan (COUNT_LIM0..3 overridden to 4, 8, 16, 32; NB_LEDS=4):
- Reset then i_enable=1, i_sel=0:
  - o_sr_init pulses once;
  - o_valid pulses every 4 clocks, first pulse 4 clocks after o_sr_init;
  - o_pos runs 1,2,3,0; o_rot_cnt=1 after the 4th strobe.
- Running at i_sel=3, prescaler=20, switch to i_sel=1: strobe on the next cycle, then every 8 clocks.
- i_pause=1 for 50 clocks mid-count, then released: no strobes during the pause; o_pos and prescaler resume from the held values; no o_sr_init.
- i_enable=0 then 1 after 3 rotations: state→IDLE; o_rot_cnt=0 and o_pos=0; o_sr_init pulses again on restart.
- Async i_reset asserted between clock edges mid-RUN: outputs go to reset values before the next edge; no strobe follows reset release while i_enable=0.
- LED_SEQ_AUTOSTOP_EN defined, AUTOSTOP_ROTS=2, i_sel=0: after 8 strobes o_state=3 and o_done=1, with no further o_valid for 100 clocks; i_enable=0 → o_done=0.
